// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, encodings and instruction decode for the CPU controller
package cpu_ctrl_pkg;

  // Controller states; every output is a pure function of the state
  typedef enum logic [4:0] {
    S_RST,
    S_IDLE,
    S_IF1,
    S_IF2,
    S_UPC,
    S_DEC,
    S_WIMM,
    S_RDM,
    S_CMPB,
    S_WRD,
    S_RDN,
    S_CALC,
    S_STAT,
    S_ADDR,
    S_LADR,
    S_MRD,
    S_WMEM,
    S_RDD,
    S_MWR
  } state_t;

  // Register-file read/write port select
  localparam logic [1:0] REG_RM = 2'b00;
  localparam logic [1:0] REG_RD = 2'b01;
  localparam logic [1:0] REG_RN = 2'b10;

  // Write-back source select
  localparam logic [1:0] WB_C     = 2'b00;
  localparam logic [1:0] WB_PC    = 2'b01;
  localparam logic [1:0] WB_IMM   = 2'b10;
  localparam logic [1:0] WB_MDATA = 2'b11;

  // Memory command
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Opcode field values
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU_op field values (MOV reuses 00 for register and 10 for immediate)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // Instruction classes the FSM branches on
  typedef enum logic [3:0] {
    I_MOVI, I_MOVR, I_ADD, I_AND, I_MVN, I_CMP, I_LDR, I_STR, I_HALT, I_BAD
  } instr_t;

  // Map the IR fields to an instruction class; anything unlisted is illegal
  function automatic instr_t decode_instr(input logic [2:0] op, input logic [1:0] alu);
    instr_t r;
    r = I_BAD;
    case (op)
      OP_MOV: begin
        if (alu == MOV_IMM) r = I_MOVI;
        else if (alu == MOV_REG) r = I_MOVR;
      end
      OP_ALU: begin
        case (alu)
          ALU_ADD: r = I_ADD;
          ALU_CMP: r = I_CMP;
          ALU_AND: r = I_AND;
          default: r = I_MVN;
        endcase
      end
      OP_LDR:  if (alu == 2'b00) r = I_LDR;
      OP_STR:  if (alu == 2'b00) r = I_STR;
      OP_HALT: r = I_HALT;
      default: r = I_BAD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// rtl/mem_wait_ctr.sv - loadable down-counter that paces held memory accesses
module mem_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load on entry to a held state, then count down and stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/cpu_fsm_controller.sv
// rtl/cpu_fsm_controller.sv - multi-cycle fetch/decode/execute controller for the RISC datapath
module cpu_fsm_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       waiting,
  output logic       illegal,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_t state;
  state_t next_state;
  instr_t instr;
  logic   ctr_load;
  logic   ctr_done;

  // Status flags are reserved for branch instructions
  logic unused_flags;
  assign unused_flags = Z ^ N ^ V;

  assign instr = decode_instr(opcode, ALU_op);

  // Restart the wait counter whenever a held memory state is freshly entered
  assign ctr_load = (next_state != state) &&
                    ((next_state == S_IF1) || (next_state == S_MRD) || (next_state == S_MWR));

  mem_wait_ctr #(
    .WIDTH (CW)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (CW'(MEM_WAIT)),
    .done     (ctr_done)
  );

  // State register; reset aborts any instruction immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= next_state;
  end

  // Next-state: fetch sequence, decode branch and per-instruction step chains
  always_comb begin
    next_state = state;
    case (state)
      S_RST:  next_state = S_IDLE;
      S_IDLE: if (start) next_state = S_IF1;
      S_IF1:  if (ctr_done) next_state = S_IF2;
      S_IF2:  next_state = S_UPC;
      S_UPC:  next_state = S_DEC;
      S_DEC: begin
        case (instr)
          I_MOVI:                              next_state = S_WIMM;
          I_MOVR, I_MVN:                       next_state = S_RDM;
          I_ADD, I_AND, I_CMP, I_LDR, I_STR:   next_state = S_RDN;
          I_HALT:                              next_state = S_IDLE;
          default:                             next_state = S_IF1;
        endcase
      end
      S_RDN:  next_state = ((instr == I_LDR) || (instr == I_STR)) ? S_ADDR : S_RDM;
      S_RDM: begin
        case (instr)
          I_ADD, I_AND: next_state = S_CALC;
          I_CMP:        next_state = S_STAT;
          default:      next_state = S_CMPB;
        endcase
      end
      S_CMPB: next_state = (instr == I_STR) ? S_MWR : S_WRD;
      S_CALC: next_state = S_WRD;
      S_ADDR: next_state = S_LADR;
      S_LADR: next_state = (instr == I_STR) ? S_RDD : S_MRD;
      S_RDD:  next_state = S_CMPB;
      S_MRD:  if (ctr_done) next_state = S_WMEM;
      S_MWR:  if (ctr_done) next_state = S_IF1;
      S_WIMM, S_WRD, S_STAT, S_WMEM: next_state = S_IF1;
      default: next_state = S_RST;
    endcase
  end

  // Moore outputs: everything low unless the current state asserts it
  always_comb begin
    waiting   = 1'b0;
    illegal   = 1'b0;
    reg_sel   = REG_RM;
    wb_sel    = WB_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_pc   = 1'b0;
    clear_pc  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    case (state)
      S_RST: begin
        clear_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IDLE: waiting = 1'b1;
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPC: load_pc = 1'b1;
      S_DEC: illegal = (instr == I_BAD);
      S_WIMM: begin
        reg_sel = REG_RN;
        wb_sel  = WB_IMM;
        w_en    = 1'b1;
      end
      S_RDM: begin
        reg_sel = REG_RM;
        en_B    = 1'b1;
      end
      S_CMPB: begin
        sel_A = 1'b1;
        en_C  = 1'b1;
      end
      S_WRD: begin
        reg_sel = REG_RD;
        wb_sel  = WB_C;
        w_en    = 1'b1;
      end
      S_RDN: begin
        reg_sel = REG_RN;
        en_A    = 1'b1;
      end
      S_CALC: en_C = 1'b1;
      S_STAT: en_status = 1'b1;
      S_ADDR: begin
        sel_B = 1'b1;
        en_C  = 1'b1;
      end
      S_LADR: load_addr = 1'b1;
      S_MRD:  mem_cmd = MEM_READ;
      S_WMEM: begin
        reg_sel = REG_RD;
        wb_sel  = WB_MDATA;
        w_en    = 1'b1;
      end
      S_RDD: begin
        reg_sel = REG_RD;
        en_B    = 1'b1;
      end
      S_MWR:  mem_cmd = MEM_WRITE;
      default: ;
    endcase
  end

endmodule
